// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer for the shared
// byte-wide data memory. Port 0 is the pipeline MEM stage, port 1 the
// debug/loader port. One request is granted at a time. The command is
// latched, the memory strobes are held for MEM_LAT cycles, read data is
// captured, and a one-cycle done pulse is returned to the owner.
//
// Build option: define DMEM_ARB_FIXED_PRIO_EN to make port 0 always win
// simultaneous requests. The round-robin pointer is then removed.
// Without the macro, simultaneous requests are served round-robin.
module dmem_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // port 0: pipeline MEM stage
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              gnt0_o,
  output logic              done0_o,
  output logic [DATA_W-1:0] rdata0_o,
  // port 1: debug/loader
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt1_o,
  output logic              done1_o,
  output logic [DATA_W-1:0] rdata1_o,
  // memory side
  output logic              memRead_o,
  output logic              memWrite_o,
  output logic [ADDR_W-1:0] memAddr_o,
  output logic [DATA_W-1:0] memWData_o,
  input  logic [DATA_W-1:0] memRData_i
);

  // MEM_LAT is limited to 1..15, so a 4-bit down-counter is enough.
  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic               owner_reg, owner_next;   // port that holds the grant
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               we_reg, we_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [DATA_W-1:0]  wdata_reg, wdata_next;
  logic               capture;                 // last ACCESS cycle
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic               ptr_reg, ptr_next;       // port favoured on a tie
`endif

  // Per-port views of the request inputs, so ports can be indexed by owner.
  logic [1:0]         req_vec, we_vec;
  logic [ADDR_W-1:0]  addr_arr  [2];
  logic [DATA_W-1:0]  wdata_arr [2];
  logic [1:0]         gnt_vec, done_vec;
  logic [DATA_W-1:0]  rdata_reg [2];

  assign req_vec      = {req1_i, req0_i};
  assign we_vec       = {we1_i, we0_i};
  assign addr_arr[0]  = addr0_i;
  assign addr_arr[1]  = addr1_i;
  assign wdata_arr[0] = wdata0_i;
  assign wdata_arr[1] = wdata1_i;

  // State register, latched command, access counter and arbitration pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      ptr_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      ptr_reg   <= ptr_next;
`endif
    end
  end

  // Next state: arbitrate and latch in IDLE, count down in ACCESS, one DONE cycle.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    capture    = 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    ptr_next   = ptr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (req_vec != 2'b00) begin
          if (req_vec == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            owner_next = 1'b0;
`else
            // The pointer moves only when it actually breaks a tie.
            owner_next = ptr_reg;
            ptr_next   = ~ptr_reg;
`endif
          end else begin
            owner_next = req_vec[1];
          end
          we_next    = we_vec[owner_next];
          addr_next  = addr_arr[owner_next];
          wdata_next = wdata_arr[owner_next];
          cnt_next   = CNT_LOAD;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        // Requests are ignored here. A held request is seen again in IDLE.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-port grant and done flags, decoded from the state and the current owner.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign gnt_vec[gi]  = (state_reg != IDLE) && (owner_reg == 1'(gi));
    assign done_vec[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
  end

  // Read-data holding registers. Only the owner's register changes, and only on a read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        rdata_reg[i] <= '0;
      end
    end else if (capture && !we_reg) begin
      for (int i = 0; i < 2; i++) begin
        if (owner_reg == 1'(i)) begin
          rdata_reg[i] <= memRData_i;
        end
      end
    end
  end

  assign gnt0_o   = gnt_vec[0];
  assign gnt1_o   = gnt_vec[1];
  assign done0_o  = done_vec[0];
  assign done1_o  = done_vec[1];
  assign rdata0_o = rdata_reg[0];
  assign rdata1_o = rdata_reg[1];

  // Memory-side outputs are driven only during ACCESS, so a reset clears them at once.
  assign memRead_o  = (state_reg == ACCESS) && !we_reg;
  assign memWrite_o = (state_reg == ACCESS) &&  we_reg;
  assign memAddr_o  = (state_reg == ACCESS) ? addr_reg  : '0;
  assign memWData_o = (state_reg == ACCESS) ? wdata_reg : '0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared byte-wide data memory (32 entries).
- Port 0 is the pipeline MEM stage; port 1 is the debug/loader port.
- Grants one requester at a time, drives the memory's read/write strobes for a fixed number of cycles, captures read data and returns a one-cycle completion pulse.
- Default arbitration is round-robin.

Parameters:
- ADDR_W, 5, address width; memory depth is 2**ADDR_W.
- DATA_W, 32, requester data width. Memory stores the low 8 bits; reads return zero-extended data.
- MEM_LAT, 1, cycles each access is held on the memory side. Legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req0_i  in  1  port 0 request; held until done0_o.
- we0_i  in  1  port 0: 1 = write, 0 = read.
- addr0_i  in  ADDR_W  port 0 address.
- wdata0_i  in  DATA_W  port 0 write data.
- gnt0_o  out  1  port 0 granted (high from ACCESS entry through DONE).
- done0_o  out  1  one-cycle completion pulse for port 0.
- rdata0_o  out  DATA_W  port 0 read data; valid when done0_o is high, held until the next port 0 read completes.
- req1_i, we1_i, addr1_i, wdata1_i, gnt1_o, done1_o, rdata1_o  same as port 0, for port 1.
- memRead_o  out  1  memory read strobe.
- memWrite_o  out  1  memory write strobe.
- memAddr_o  out  ADDR_W  memory address.
- memWData_o  out  DATA_W  memory write data.
- memRData_i  in  DATA_W  memory read data.

Behaviour:
- Reset (asynchronous, rst_i high): state = IDLE, priority pointer = port 0, all outputs 0 (gnt*, done*, rdata*, mem strobes, memAddr_o, memWData_o). Reset mid-access aborts the access with no done pulse; a partially strobed write has an undefined memory effect.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one reqN_i is high, grant port N.
  - If both are high, grant the port named by the priority pointer. The pointer then moves to the other port. It is updated only on a grant made while both were requesting.
  - On grant: latch we, addr and wdata into internal registers; set gntN_o; load the counter with MEM_LAT-1; go to ACCESS.
  - No request: stay in IDLE, all strobes low.
- ACCESS:
  - memAddr_o and memWData_o come from the latched registers.
  - memWrite_o = latched we; memRead_o = ~latched we.
  - The counter decrements each cycle. When it reaches 0, capture memRData_i into rdataN_o (reads only) and go to DONE.
  - Duration is exactly MEM_LAT cycles.
- DONE:
  - Strobes low; doneN_o = 1 for exactly this cycle; gntN_o still high.
  - Next state is IDLE, where gnt is cleared. Requests are ignored in DONE.
- Turnaround: one transaction occupies MEM_LAT+2 cycles from grant edge to the next IDLE. A requester holding req high after done is treated as a new request in IDLE.
- Changes to reqN/we/addr/wdata after grant are ignored, because the command is latched. A req drop during ACCESS does not cancel the access; done still pulses.
- rdataN_o is unchanged on writes and on the other port's transactions.
- memRead_o and memWrite_o are never high together and never high outside ACCESS.
- At most one gnt and at most one done are high in any cycle.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins simultaneous requests; the priority pointer is removed.
- Undefined: round-robin arbitration as above.
- Port 1 starvation under continuous port 0 traffic is accepted when the macro is defined.

Test Plan:
- Reset check: assert rst_i mid-ACCESS (MEM_LAT=3, cycle 2) -> all outputs 0 immediately. After release, first req1 read of address 4 completes normally with done1 after 3 ACCESS cycles.
- Single write then read: port 0 writes 0x000000A5 to address 7, then reads address 7 -> memWrite_o high 1 cycle; done0 pulses; rdata0_o = 0x000000A5 on the read's done cycle.
- Simultaneous requests, round-robin: req0 and req1 held high for 4 transactions -> grant order 0,1,0,1. Each done is separated by MEM_LAT+2 cycles, and gnt0/gnt1 are never high together.
- Same stimulus with DMEM_ARB_FIXED_PRIO_EN defined -> grant order 0,0,0,0; port 1 is granted only after req0 drops.
- Latching: after grant, change addr0_i from 3 to 9 and we0_i 0 -> 1 -> memAddr_o stays 3, the access stays a read, and done0 still pulses.
- Latency sweep MEM_LAT=1 and 4: read of address 31 (wrap edge) -> strobe width equals MEM_LAT, done exactly MEM_LAT+1 cycles after grant, rdata1_o equals the preloaded memory byte.
